// File: rtl/full_adder_pkg.sv
// full_adder_pkg: shared constants for the full_adder datapath leaf
package full_adder_pkg;
    localparam int unsigned FA_DEFAULT_WIDTH = 1;
endpackage

// File: rtl/full_adder_fa_cell.sv
// fa_cell: 1-bit combinational full adder cell
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/full_adder.sv
// full_adder: WIDTH-bit ripple-carry adder with a one-cycle registered copy of the result
module full_adder
    import full_adder_pkg::*;
#(
    parameter int unsigned WIDTH = FA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [WIDTH-1:0] sum_q,
    output logic             cout_q
);
    logic [WIDTH:0] c;
    assign c[0] = cin;
    assign cout = c[WIDTH];
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        fa_cell u_cell (
            .a (a[i]),
            .b (b[i]),
            .ci(c[i]),
            .s (sum[i]),
            .co(c[i+1])
        );
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum;
            cout_q <= cout;
        end
    end
endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: directed and random checks of full_adder at WIDTH=1 and WIDTH=8
module tb_full_adder;
    logic clk = 1'b0;
    logic rst_n;
    logic a1, b1, c1, s1, co1, s1_q, co1_q;
    logic [7:0] a8, b8, s8, s8_q;
    logic c8, co8, co8_q;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(c1),
        .sum(s1), .cout(co1), .sum_q(s1_q), .cout_q(co1_q)
    );
    full_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(c8),
        .sum(s8), .cout(co8), .sum_q(s8_q), .cout_q(co8_q)
    );

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] ref_add(input int x, input int y, input int ci);
        int t;
        t = x + y + ci;
        return t[8:0];
    endfunction

    initial begin
        logic [8:0] exp;
        logic [8:0] q[$];
        rst_n = 1'b0;
        {a1, b1, c1} = 3'b111;
        a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold_q1", {7'd0, co1_q, s1_q}, 9'd0);
            chk("rst_hold_q8", {co8_q, s8_q}, 9'd0);
        end
        for (int i = 0; i < 8; i++) begin
            {a1, b1, c1} = 3'(i);
            #20;
            chk($sformatf("tt_%0d", i), {7'd0, co1, s1}, ref_add(int'(a1), int'(b1), int'(c1)));
        end
        {a1, b1, c1} = 3'b111;
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("release_no_edge", {7'd0, co1_q, s1_q}, 9'd0);
        @(negedge clk);
        chk("release_first_cap", {7'd0, co1_q, s1_q}, 9'b11);
        {a1, b1, c1} = 3'b101;
        @(negedge clk);
        chk("lat_101_q", {7'd0, co1_q, s1_q}, 9'b10);
        {a1, b1, c1} = 3'b000;
        #1 chk("lat_000_comb", {7'd0, co1, s1}, 9'b00);
        chk("lat_000_q_hold", {7'd0, co1_q, s1_q}, 9'b10);
        @(negedge clk);
        chk("lat_000_q", {7'd0, co1_q, s1_q}, 9'b00);
        {a1, b1, c1} = 3'b111;
        a8 = 8'hA5; b8 = 8'h3C; c8 = 1'b1;
        @(negedge clk);
        chk("pre_async_q1", {7'd0, co1_q, s1_q}, 9'b11);
        chk("pre_async_q8", {co8_q, s8_q}, ref_add(8'hA5, 8'h3C, 1));
        #2 rst_n = 1'b0;
        #1;
        chk("async_q1", {7'd0, co1_q, s1_q}, 9'd0);
        chk("async_q8", {co8_q, s8_q}, 9'd0);
        chk("async_comb1", {7'd0, co1, s1}, 9'b11);
        chk("async_comb8", {co8, s8}, ref_add(8'hA5, 8'h3C, 1));
        @(negedge clk);
        rst_n = 1'b1;
        a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1;
        #1 chk("bnd_ff_00_1", {co8, s8}, 9'h100);
        @(negedge clk);
        chk("bnd_ff_00_1_q", {co8_q, s8_q}, 9'h100);
        a8 = 8'h7F; b8 = 8'h01; c8 = 1'b0;
        #1 chk("bnd_7f_01_0", {co8, s8}, 9'h080);
        @(negedge clk);
        chk("bnd_7f_01_0_q", {co8_q, s8_q}, 9'h080);
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
        #1 chk("bnd_ff_ff_1", {co8, s8}, 9'h1FF);
        @(negedge clk);
        chk("bnd_ff_ff_1_q", {co8_q, s8_q}, 9'h1FF);
        for (int n = 0; n < 1000; n++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            c8 = 1'($urandom);
            exp = ref_add(int'(a8), int'(b8), int'(c8));
            q.push_back(exp);
            #1 chk("rand_comb", {co8, s8}, exp);
            @(negedge clk);
            chk("rand_q", {co8_q, s8_q}, q.pop_front());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
